// File: rtl/seg7_pkg.sv
// Shared types and constants for the seg7_scan_display 7-segment scan driver.
package seg7_pkg;

   localparam int unsigned SEG_W = 8;

   typedef enum logic {ST_BLANK, ST_DRIVE} state_e;

   // Hex nibble to gfedcba pattern, active-high.
   function automatic logic [6:0] hex2seg(input logic [3:0] nib);
      logic [6:0] pat;
      case (nib)
         4'h0:    pat = 7'h3F;
         4'h1:    pat = 7'h06;
         4'h2:    pat = 7'h5B;
         4'h3:    pat = 7'h4F;
         4'h4:    pat = 7'h66;
         4'h5:    pat = 7'h6D;
         4'h6:    pat = 7'h7D;
         4'h7:    pat = 7'h07;
         4'h8:    pat = 7'h7F;
         4'h9:    pat = 7'h6F;
         4'hA:    pat = 7'h77;
         4'hB:    pat = 7'h7C;
         4'hC:    pat = 7'h39;
         4'hD:    pat = 7'h5E;
         4'hE:    pat = 7'h79;
         default: pat = 7'h71;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// Producer-side bundle of digit values/controls and the board-facing scan pins.
interface seg7_scan_display_if #(
   parameter int unsigned DIGITS = 6
);
   import seg7_pkg::*;

   logic [4*DIGITS-1:0] hex_in;
   logic [DIGITS-1:0]   dp_in;
   logic [DIGITS-1:0]   en_mask;
   logic                lzb_en;
   logic [DIGITS-1:0]   blink_mask;
   logic [SEG_W-1:0]    seg_out;
   logic [DIGITS-1:0]   cs_out;
   logic                frame_start;

   modport master (
      output hex_in, dp_in, en_mask, lzb_en, blink_mask,
      input  seg_out, cs_out, frame_start
   );

   modport slave (
      input  hex_in, dp_in, en_mask, lzb_en, blink_mask,
      output seg_out, cs_out, frame_start
   );

endinterface

// File: rtl/seg7_decode.sv
// Combinational nibble + decimal point to 8-bit active-high segment pattern.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0]       nib_i,
   input  logic             dp_i,
   output logic [SEG_W-1:0] pat_o
);

   always_comb begin
      pat_o = {dp_i, hex2seg(nib_i)};
   end

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed 7-segment scan driver with frame snapshot, blanking and polarity control.
// Optional digit blinking is built when SEG7_BLINK_EN is defined.
module seg7_scan_display
   import seg7_pkg::*;
#(
   parameter int unsigned DIGITS         = 6,
   parameter int unsigned SCAN_DIV       = 200,
   parameter int unsigned BLANK_CYC      = 4,
   parameter int unsigned SEG_ACTIVE_LOW = 1,
   parameter int unsigned CS_ACTIVE_LOW  = 1,
   parameter int unsigned BLINK_FRAMES   = 64
) (
   input logic                CLK,
   input logic                RSTn,
   seg7_scan_display_if.slave bif
);

   localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned HEX_W = 4 * DIGITS;

   // XOR masks: inactive level of each output bus, also used to apply polarity
   localparam logic [SEG_W-1:0]  SEG_OFF = (SEG_ACTIVE_LOW != 0) ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
   localparam logic [DIGITS-1:0] CS_OFF  = (CS_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
   localparam state_e            ST_RST  = (BLANK_CYC == 0) ? ST_DRIVE : ST_BLANK;

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   state_e            state_q, state_d;

   logic [HEX_W-1:0]  hex_q, hex_d;
   logic [DIGITS-1:0] dp_q, dp_d;
   logic [DIGITS-1:0] en_q, en_d;
   logic              lzb_q, lzb_d;

   logic [SEG_W-1:0]  seg_q, seg_d;
   logic [DIGITS-1:0] cs_q, cs_d;
   logic              fs_q, fs_d;

   logic              snap_c;
   logic [DIGITS-1:0] lz_c;
   logic [DIGITS-1:0] hot_c;
   logic [3:0]        nib_c;
   logic              dp_c;
   logic              sup_c;
   logic [SEG_W-1:0]  pat_c;
   logic              blink_off_c;
   logic [DIGITS-1:0] bmask_c;

   // Slot/digit counters, per-slot FSM and frame snapshot
   always_comb begin
      snap_c  = (cnt_q == '0) && (idx_q == '0);
      cnt_d   = cnt_q + CNT_W'(1);
      idx_d   = idx_q;
      if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
         cnt_d = '0;
         idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end
      state_d = (32'(cnt_d) < BLANK_CYC) ? ST_BLANK : ST_DRIVE;

      hex_d = hex_q;
      dp_d  = dp_q;
      en_d  = en_q;
      lzb_d = lzb_q;
      if (snap_c) begin
         hex_d = bif.hex_in;
         dp_d  = bif.dp_in;
         en_d  = bif.en_mask;
         lzb_d = bif.lzb_en;
      end
   end

`ifdef SEG7_BLINK_EN
   localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [FRM_W-1:0]  frm_q, frm_d;
   logic              ph_q, ph_d;
   logic              bon_q, bon_d;
   logic [DIGITS-1:0] bm_q, bm_d;

   // ph_q is the phase the next frame will use; bon_q holds the phase of the current frame
   always_comb begin
      frm_d = frm_q;
      ph_d  = ph_q;
      bon_d = bon_q;
      bm_d  = bm_q;
      if (snap_c) begin
         bon_d = ph_q;
         bm_d  = bif.blink_mask;
         if (frm_q == FRM_W'(BLINK_FRAMES - 1)) begin
            frm_d = '0;
            ph_d  = ~ph_q;
         end else begin
            frm_d = frm_q + FRM_W'(1);
         end
      end
      blink_off_c = ~bon_d;
      bmask_c     = bm_d;
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         frm_q <= '0;
         ph_q  <= 1'b1;
         bon_q <= 1'b1;
         bm_q  <= '0;
      end else begin
         frm_q <= frm_d;
         ph_q  <= ph_d;
         bon_q <= bon_d;
         bm_q  <= bm_d;
      end
   end
`else
   always_comb begin
      blink_off_c = 1'b0;
      bmask_c     = (BLINK_FRAMES != 0) ? bif.blink_mask : '0;
   end
`endif

   // Leading-zero chain runs from the top digit down; disabled digits let it pass
   always_comb begin
      logic run;
      logic zero;
      lz_c = '0;
      run  = lzb_d;
      zero = 1'b0;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         zero    = (hex_d[4*k +: 4] == 4'h0) && !dp_d[k];
         lz_c[k] = run && zero;
         run     = run && (zero || !en_d[k]);
      end
   end

   // Selected-digit mux and suppression decision
   always_comb begin
      nib_c = 4'h0;
      dp_c  = 1'b0;
      sup_c = 1'b1;
      hot_c = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (IDX_W'(k) == idx_q) begin
            nib_c    = hex_d[4*k +: 4];
            dp_c     = dp_d[k];
            sup_c    = !en_d[k] || lz_c[k] || (blink_off_c && bmask_c[k]);
            hot_c[k] = 1'b1;
         end
      end
   end

   seg7_decode u_decode (
      .nib_i (nib_c),
      .dp_i  (dp_c),
      .pat_o (pat_c)
   );

   // Output staging: polarity applied last via the off-level masks
   always_comb begin
      seg_d = SEG_OFF;
      cs_d  = CS_OFF;
      fs_d  = snap_c;
      if (state_q == ST_DRIVE && !sup_c) begin
         seg_d = pat_c ^ SEG_OFF;
         cs_d  = hot_c ^ CS_OFF;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         cnt_q   <= '0;
         idx_q   <= '0;
         state_q <= ST_RST;
         hex_q   <= '0;
         dp_q    <= '0;
         en_q    <= '0;
         lzb_q   <= 1'b0;
         seg_q   <= SEG_OFF;
         cs_q    <= CS_OFF;
         fs_q    <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         state_q <= state_d;
         hex_q   <= hex_d;
         dp_q    <= dp_d;
         en_q    <= en_d;
         lzb_q   <= lzb_d;
         seg_q   <= seg_d;
         cs_q    <= cs_d;
         fs_q    <= fs_d;
      end
   end

   assign bif.seg_out     = seg_q;
   assign bif.cs_out      = cs_q;
   assign bif.frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: 6 digits, 8 clocks/slot, 2 blank clocks, active-low.
module tb_seg7_scan_display;

   localparam int unsigned DIGITS       = 6;
   localparam int unsigned SCAN_DIV     = 8;
   localparam int unsigned BLANK_CYC    = 2;
   localparam int unsigned BLINK_FRAMES = 2;
   localparam int unsigned FRAME_LEN    = DIGITS * SCAN_DIV;

   localparam logic [6:0] SEG_TBL [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

`ifdef SEG7_BLINK_EN
   localparam bit BLINK_BUILT = 1'b1;
`else
   localparam bit BLINK_BUILT = 1'b0;
`endif

   typedef struct packed {
      logic [5:0] cs;
      logic [7:0] seg;
   } exp_t;

   localparam exp_t IDLE = '{cs: 6'h3F, seg: 8'hFF};

   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t exp_q[$];

   seg7_scan_display_if #(.DIGITS(DIGITS)) bif ();

   seg7_scan_display #(
      .DIGITS         (DIGITS),
      .SCAN_DIV       (SCAN_DIV),
      .BLANK_CYC      (BLANK_CYC),
      .SEG_ACTIVE_LOW (1),
      .CS_ACTIVE_LOW  (1),
      .BLINK_FRAMES   (BLINK_FRAMES)
   ) dut (
      .CLK  (clk),
      .RSTn (rst_n),
      .bif  (bif)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference behaviour of one digit slot, written from the display rules
   function automatic exp_t exp_slot(input int k, input logic [23:0] hex, input logic [5:0] dp,
                                     input logic [5:0] en, input logic lzb,
                                     input logic [5:0] bm, input logic boff);
      exp_t       e;
      logic       sup;
      logic       lz;
      logic       zero;
      logic [3:0] nib;
      logic [5:0] hot;
      sup = !en[k] || (boff && bm[k]);
      if (lzb && k > 0) begin
         lz = 1'b1;
         for (int j = k; j < 6; j++) begin
            zero = (hex[4*j +: 4] == 4'h0) && !dp[j];
            if (j == k) lz = lz && zero;
            else        lz = lz && (zero || !en[j]);
         end
         sup = sup || lz;
      end
      if (sup) return IDLE;
      nib    = hex[4*k +: 4];
      hot    = 6'b000001 << k;
      e.cs   = ~hot;
      e.seg  = ~{dp[k], SEG_TBL[nib]};
      return e;
   endfunction

   task automatic push_frame(input logic boff);
      for (int k = 0; k < 6; k++)
         exp_q.push_back(exp_slot(k, bif.hex_in, bif.dp_in, bif.en_mask, bif.lzb_en,
                                  bif.blink_mask, boff));
   endtask

   // Called in the cycle the frame should start; walks the whole frame
   task automatic check_frame(input bit mid_chg, input logic [23:0] mid_hex);
      exp_t e;
      e = IDLE;
      check_eq("frame_start", 32'(bif.frame_start), 32'd1);
      for (int t = 0; t < int'(FRAME_LEN); t++) begin
         int s;
         int c;
         s = t / int'(SCAN_DIV);
         c = t % int'(SCAN_DIV);
         if (t > 0) step();
         if (c == 0 && s > 0)
            check_eq($sformatf("fs_low_s%0d", s), 32'(bif.frame_start), 32'd0);
         if (c == 1)
            check_eq($sformatf("blank_s%0d", s), 32'({bif.cs_out, bif.seg_out}), 32'(IDLE));
         if (c == int'(BLANK_CYC)) begin
            if (exp_q.size() == 0) begin
               check_eq("scoreboard_underflow", 32'd0, 32'd1);
               e = IDLE;
            end else begin
               e = exp_q.pop_front();
            end
            check_eq($sformatf("drive_s%0d_first", s), 32'({bif.cs_out, bif.seg_out}), 32'(e));
         end
         if (c == int'(SCAN_DIV) - 1)
            check_eq($sformatf("drive_s%0d_last", s), 32'({bif.cs_out, bif.seg_out}), 32'(e));
         if (mid_chg && t == 20) begin
            bif.hex_in = mid_hex;
            push_frame(1'b0);
         end
      end
   endtask

   initial begin
      rst_n          = 1'b0;
      bif.hex_in     = 24'h12345A;
      bif.dp_in      = 6'h00;
      bif.en_mask    = 6'h3F;
      bif.lzb_en     = 1'b0;
      bif.blink_mask = 6'h00;
      #12;
      check_eq("rst_cs", 32'(bif.cs_out), 32'h3F);
      check_eq("rst_seg", 32'(bif.seg_out), 32'hFF);
      check_eq("rst_fs", 32'(bif.frame_start), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic scan; first frame_start right after release
      push_frame(1'b0);
      step();
      check_frame(1'b0, 24'h0);

      // Mid-frame change is held off until the next frame
      push_frame(1'b0);
      step();
      check_frame(1'b1, 24'hFFFFFF);
      step();
      check_frame(1'b0, 24'h0);

      // Leading-zero blanking, then a dp stopping it
      bif.hex_in = 24'h000050;
      bif.lzb_en = 1'b1;
      push_frame(1'b0);
      step();
      check_frame(1'b0, 24'h0);
      bif.dp_in = 6'b001000;
      push_frame(1'b0);
      step();
      check_frame(1'b0, 24'h0);

      // Per-digit enable
      bif.lzb_en  = 1'b0;
      bif.dp_in   = 6'h00;
      bif.hex_in  = 24'h12345A;
      bif.en_mask = 6'b000011;
      push_frame(1'b0);
      step();
      check_frame(1'b0, 24'h0);

      // Asynchronous reset in the middle of a driven slot
      for (int i = 0; i < 5; i++) step();
      check_eq("pre_rst_drive", 32'({bif.cs_out, bif.seg_out}), 32'({6'b111110, ~8'h77}));
      #1 rst_n = 1'b0;
      #1;
      check_eq("async_rst_cs", 32'(bif.cs_out), 32'h3F);
      check_eq("async_rst_seg", 32'(bif.seg_out), 32'hFF);
      check_eq("async_rst_fs", 32'(bif.frame_start), 32'd0);

      // Blink on digit 0: off in frames 2-3 only when the feature is built
      bif.en_mask    = 6'h3F;
      bif.blink_mask = 6'b000001;
      @(negedge clk);
      rst_n = 1'b1;
      for (int f = 0; f < 6; f++) begin
         push_frame(BLINK_BUILT && (f == 2 || f == 3));
         step();
         check_frame(1'b0, 24'h0);
      end

      check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
Parametrised multiplexed 7-segment scan driver. Next generation of the 6-digit fixed scanner, with:
- configurable digit count and scan rate
- decimal points, per-digit enable and leading-zero blanking
- an anti-ghosting blank interval
- frame-coherent input snapshot
- selectable output polarity
Sits between display-value producers (counters, timers, registers) and the board digit/segment pins.

Parameters:
DIGITS, 6, number of digits (1..8)
SCAN_DIV, 200, clocks per digit slot (>= BLANK_CYC+2)
BLANK_CYC, 4, clocks at start of each slot with all outputs inactive (0 = no blanking)
SEG_ACTIVE_LOW, 1, 1: seg_out low = segment lit
CS_ACTIVE_LOW, 1, 1: cs_out low = digit selected
BLINK_FRAMES, 64, frames per blink half-period (used only with SEG7_BLINK_EN)

Ports:
CLK  in  1  system clock, single clock domain
RSTn  in  1  asynchronous active-low reset
hex_in  in  4*DIGITS  nibble k = digit k; digit 0 is rightmost
dp_in  in  DIGITS  decimal point per digit
en_mask  in  DIGITS  1 = digit may be driven
lzb_en  in  1  leading-zero blanking enable
blink_mask  in  DIGITS  1 = digit blinks (ignored without SEG7_BLINK_EN)
seg_out  out  8  bit7 = dp, bits6:0 = g..a, polarity per SEG_ACTIVE_LOW
cs_out  out  DIGITS  one-hot digit select, polarity per CS_ACTIVE_LOW
frame_start  out  1  one-cycle pulse when slot 0 of a frame begins

Behaviour:
- Reset (async, RSTn=0):
  - slot counter=0, digit index=0, state=BLANK (DRIVE if BLANK_CYC=0)
  - shadow regs=0, frame_start=0
  - cs_out all inactive, seg_out all off (0xFF when active-low)
- Slot counter 0..SCAN_DIV-1.
  - At SCAN_DIV-1 the counter wraps, and the index advances DIGITS-1 -> 0.
  - Frame length = DIGITS*SCAN_DIV clocks.
- Snapshot: hex_in, dp_in, en_mask and lzb_en are captured into shadow regs on every cycle with counter==0 and index==0, including the first cycle after reset release.
  - Mid-frame input changes are not displayed until the next frame.
- frame_start: registered; high during the cycle counter==0 and index==0.
- FSM per slot:
  - BLANK: counter < BLANK_CYC; cs all inactive, seg all off.
  - DRIVE: counter >= BLANK_CYC through end of slot. Selected digit's cs active and its pattern on seg_out.
  - DRIVE -> BLANK at slot wrap.
- All outputs are registered. The digit k pattern is visible from slot cycle BLANK_CYC to the end of the slot.
- Digit k is suppressed (cs inactive, seg off for the whole slot; slot still consumed) if any of:
  - en_mask[k]=0
  - it is leading-zero-blanked
  - it is in a blink-off phase
- Leading-zero blanking (shadow lzb_en=1):
  - Scanning from digit DIGITS-1 downward, a digit is blanked while its nibble=0, dp=0 and all higher digits are blanked.
  - Digit 0 is never blanked.
  - A disabled digit does not stop blanking propagation.
- Decode gfedcba, active-high before polarity:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
  - seg bit7 = dp. Polarity is applied last.
- Counter widths: clog2(SCAN_DIV) and clog2(DIGITS) (min 1). No overflow beyond the wrap points.

Optional Feature:
SEG7_BLINK_EN
- Defined:
  - Frame counter 0..BLINK_FRAMES-1 toggles a phase bit at wrap (frame_start). Phase resets to "on".
  - In the off phase, digits with blink_mask=1 are suppressed. blink_mask is sampled with the snapshot.
- Undefined: frame counter and phase bit absent; blink_mask ignored.

Decomposition:
- Package seg7_pkg holds:
  - hex-to-segment constant table/function
  - SEG_W=8
  - FSM state enum {ST_BLANK, ST_DRIVE}
- Sub-module seg7_decode (4-bit nibble + dp -> 8-bit active-high pattern, combinational), instantiated once on the selected digit.

Test Plan:
Bench uses DIGITS=6, SCAN_DIV=8, BLANK_CYC=2, active-low.
1. RSTn low mid-DRIVE -> same cycle: cs_out=6'h3F, seg_out=8'hFF. After release: frame_start pulses on the first cycle, and digit 0 is driven from cycle 2.
2. hex_in=24'h12345A, dp=0, lzb_en=0, en=6'h3F:
   - slot 0: cs=6'b111110, seg=~8'h77
   - slot 1: cs=6'b111101, seg=~8'h6D
   - slot 5: cs=6'b011111, seg=~8'h06
   - frame_start every 48 clocks; cycles 0-1 of each slot fully blank
3. Change hex_in to 24'hFFFFFF at frame cycle 20 -> slots 3-5 still show 3,2,1. The next frame shows F (~8'h71) on all digits.
4. lzb_en=1, hex_in=24'h000050 -> digits 5..2 suppressed, digit1=~8'h6D, digit0=~8'h3F. With dp_in=6'b001000, digit3 is shown as ~8'hBF ("0.").
5. en_mask=6'b000011 -> cs active only in slots 0 and 1; frame still 48 clocks; suppressed slots seg=8'hFF.
6. SEG7_BLINK_EN, BLINK_FRAMES=2, blink_mask=6'b000001 -> digit 0 driven in frames 0-1, suppressed in 2-3, driven in 4-5; other digits unaffected. Without the macro, digit 0 is always driven.
